// File: rtl/avalon_mm_lite_pkg.sv
// Shared types for the avalon_mm_lite master and its bench-side slave models.
package avalon_mm_lite_pkg;

    localparam int unsigned RspDataWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StLatency,
        StRespond
    } master_state_e;

    typedef struct packed {
        logic                    error;
        logic [RspDataWidth-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/avalon_mm_lite_if.sv
// Local command/response port plus Avalon-MM lite bus, seen from master and slave sides.
interface avalon_mm_lite_if #(
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [ADDRESS_WIDTH-1:0] cmd_address;
    logic [DATA_WIDTH-1:0]    cmd_wdata;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_error;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     read;
    logic                     write;
    logic [DATA_WIDTH-1:0]    writedata;
    logic [DATA_WIDTH-1:0]    readdata;
    logic                     waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready, readdata, waitrequest,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, address, read, write, writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready, readdata, waitrequest,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, address, read, write, writedata
    );

endinterface

// File: rtl/avalon_mm_lite_wait_timer.sv
// Saturating stall counter; expired_o flags the enabled cycle that brings the count to LIMIT.
module avalon_mm_lite_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned CntWidth = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(LIMIT);
    localparam logic [CntWidth-1:0] CntLast = (LIMIT == 0) ? '0 : CntWidth'(LIMIT - 1);

    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CntMax)) begin
            count_d = count_q + CntWidth'(1);
        end
    end

    // LIMIT of zero disables the watchdog entirely.
    assign expired_o = (LIMIT != 0) && enable_i && (count_q == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/avalon_mm_lite_master.sv
// Single-outstanding Avalon-MM lite initiator: one command in, one bus transfer, one response out.
module avalon_mm_lite_master
    import avalon_mm_lite_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk_i,
    input logic               rst_ni,
    avalon_mm_lite_if.master  bus
);
    localparam logic [2:0] LatLast = (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);

    master_state_e            state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0]    writedata_q, writedata_d;
    logic                     read_q, read_d;
    logic                     write_q, write_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     error_q, error_d;
    logic [2:0]               lat_cnt_q, lat_cnt_d;
    logic                     timer_clear, timer_enable, timer_expired;

    avalon_mm_lite_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        read_d       = read_q;
        write_d      = write_q;
        rsp_valid_d  = rsp_valid_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        lat_cnt_d    = lat_cnt_q;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    address_d   = bus.cmd_address;
                    writedata_d = bus.cmd_wdata;
                    read_d      = ~bus.cmd_write;
                    write_d     = bus.cmd_write;
                    rdata_d     = '0;
                    error_d     = 1'b0;
                    timer_clear = 1'b1;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                timer_enable = bus.waitrequest;
                // A falling waitrequest always beats the watchdog.
                if (!bus.waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (write_q) begin
                        rsp_valid_d = 1'b1;
                        state_d     = StRespond;
                    end else if (READ_LATENCY == 0) begin
                        rdata_d     = bus.readdata;
                        rsp_valid_d = 1'b1;
                        state_d     = StRespond;
                    end else begin
                        lat_cnt_d = 3'd0;
                        state_d   = StLatency;
                    end
                end else if (timer_expired) begin
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    error_d     = 1'b1;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = StRespond;
                end
            end
            StLatency: begin
                if (lat_cnt_q == LatLast) begin
                    rdata_d     = bus.readdata;
                    rsp_valid_d = 1'b1;
                    state_d     = StRespond;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            StRespond: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            address_q   <= '0;
            writedata_q <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            lat_cnt_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

    // Held low while reset is asserted even though the state register already reads idle.
    assign bus.cmd_ready = (state_q == StIdle) && rst_ni;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;
    assign bus.address   = address_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.writedata = writedata_q;

endmodule

// File: tb/tb_avalon_mm_lite_master.sv
// Directed and random transactions against two master configurations, checked per cycle.
module tb_avalon_mm_lite_master;
    import avalon_mm_lite_pkg::*;

    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned Lat0 = 0;
    localparam int unsigned To0  = 8;
    localparam int unsigned Lat1 = 2;
    localparam int unsigned To1  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    avalon_mm_lite_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    avalon_mm_lite_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    avalon_mm_lite_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(Lat0), .TIMEOUT_CYCLES(To0)
    ) dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus0)
    );

    avalon_mm_lite_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(Lat1), .TIMEOUT_CYCLES(To1)
    ) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    int            sel;
    logic          cmd_valid, cmd_write, rsp_ready, waitrequest;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_wdata, readdata;

    assign bus0.cmd_valid   = cmd_valid && (sel == 0);
    assign bus1.cmd_valid   = cmd_valid && (sel == 1);
    assign bus0.cmd_write   = cmd_write;
    assign bus1.cmd_write   = cmd_write;
    assign bus0.cmd_address = cmd_address;
    assign bus1.cmd_address = cmd_address;
    assign bus0.cmd_wdata   = cmd_wdata;
    assign bus1.cmd_wdata   = cmd_wdata;
    assign bus0.rsp_ready   = rsp_ready && (sel == 0);
    assign bus1.rsp_ready   = rsp_ready && (sel == 1);
    assign bus0.readdata    = readdata;
    assign bus1.readdata    = readdata;
    assign bus0.waitrequest = waitrequest;
    assign bus1.waitrequest = waitrequest;

    wire          o_cmd_ready = (sel == 0) ? bus0.cmd_ready : bus1.cmd_ready;
    wire          o_rsp_valid = (sel == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    wire [DW-1:0] o_rsp_rdata = (sel == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
    wire          o_rsp_error = (sel == 0) ? bus0.rsp_error : bus1.rsp_error;
    wire [AW-1:0] o_address   = (sel == 0) ? bus0.address   : bus1.address;
    wire          o_read      = (sel == 0) ? bus0.read      : bus1.read;
    wire          o_write     = (sel == 0) ? bus0.write     : bus1.write;
    wire [DW-1:0] o_writedata = (sel == 0) ? bus0.writedata : bus1.writedata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (dut%0d): observed %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    // Transaction-level model: the bus is held for min(stalls+1, timeout) cycles, a read that
    // completes returns the slave word presented on the capture cycle, a timeout returns error.
    task automatic run_txn(input int d, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                           input int stalls, input int hold);
        int   lat, to, nact, nlat;
        bit   err;
        rsp_t exp;
        lat  = (d == 0) ? Lat0 : Lat1;
        to   = (d == 0) ? To0 : To1;
        err  = (to != 0) && (stalls >= to);
        nact = err ? to : stalls + 1;
        nlat = (wr || err) ? 0 : lat;
        exp.error = err;
        exp.rdata = (err || wr) ? '0 : rd;

        @(posedge clk); #1;
        sel         = d;
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = a;
        cmd_wdata   = wd;
        rsp_ready   = 1'b0;
        waitrequest = 1'($urandom);
        readdata    = $urandom;
        @(negedge clk);
        chk("cmd_ready_idle", o_cmd_ready, 1);
        chk("idle_read", o_read, 0);
        @(posedge clk); #1;

        for (int k = 0; k < nact; k++) begin
            cmd_valid   = 1'($urandom);
            cmd_address = AW'($urandom);
            cmd_wdata   = $urandom;
            waitrequest = (k < stalls);
            readdata    = (!wr && !err && lat == 0 && k == nact - 1) ? rd : $urandom;
            @(negedge clk);
            chk("access_read", o_read, !wr);
            chk("access_write", o_write, wr);
            chk("access_address", o_address, a);
            if (wr) chk("access_writedata", o_writedata, wd);
            chk("access_rsp_valid", o_rsp_valid, 0);
            chk("access_cmd_ready", o_cmd_ready, 0);
            @(posedge clk); #1;
        end

        for (int k = 0; k < nlat; k++) begin
            waitrequest = 1'($urandom);
            readdata    = (k == nlat - 1) ? rd : $urandom;
            @(negedge clk);
            chk("latency_read", o_read, 0);
            chk("latency_rsp_valid", o_rsp_valid, 0);
            @(posedge clk); #1;
        end

        for (int k = 0; k <= hold; k++) begin
            rsp_ready   = (k == hold);
            cmd_valid   = 1'($urandom);
            waitrequest = 1'($urandom);
            readdata    = $urandom;
            @(negedge clk);
            chk("rsp_valid", o_rsp_valid, 1);
            chk("rsp_rdata", o_rsp_rdata, exp.rdata);
            chk("rsp_error", o_rsp_error, exp.error);
            chk("rsp_read", o_read, 0);
            chk("rsp_write", o_write, 0);
            chk("rsp_cmd_ready", o_cmd_ready, 0);
            @(posedge clk); #1;
        end

        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", o_rsp_valid, 0);
        chk("post_cmd_ready", o_cmd_ready, 1);
    endtask

    initial begin
        sel         = 0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_address = '0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        waitrequest = 1'b0;
        readdata    = '0;

        #2 rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            chk("reset_cmd_ready", o_cmd_ready, 0);
            chk("reset_read", o_read, 0);
            chk("reset_write", o_write, 0);
            chk("reset_rsp_valid", o_rsp_valid, 0);
            chk("reset_rsp_rdata", o_rsp_rdata, 0);
            chk("reset_rsp_error", o_rsp_error, 0);
            chk("reset_address", o_address, 0);
            chk("reset_writedata", o_writedata, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1 chk("release_cmd_ready", o_cmd_ready, 1);
        end

        run_txn(0, 1'b1, 4'd3, 32'hDEADBEEF, 32'h0, 0, 0);
        run_txn(0, 1'b0, 4'd5, 32'h0, 32'h12345678, 4, 0);
        run_txn(1, 1'b0, 4'd1, 32'h0, 32'hCAFEF00D, 0, 1);
        run_txn(0, 1'b0, 4'd9, 32'h0, 32'h000055AA, 20, 0);
        run_txn(0, 1'b0, 4'd7, 32'h0, 32'hA5A5A5A5, 7, 0);
        run_txn(0, 1'b1, 4'd8, 32'h0BADF00D, 32'h0, 8, 0);
        run_txn(0, 1'b0, 4'd2, 32'h0, 32'h87654321, 0, 10);
        run_txn(1, 1'b0, 4'd15, 32'h0, 32'h13579BDF, 12, 2);
        run_txn(1, 1'b1, 4'd0, 32'hFFFFFFFF, 32'h0, 3, 0);

        for (int i = 0; i < 60; i++) begin
            run_txn($urandom_range(0, 1), 1'($urandom), AW'($urandom), $urandom, $urandom,
                    $urandom_range(0, 10), $urandom_range(0, 3));
        end

        // Reset in the middle of a stalled read.
        @(posedge clk); #1;
        sel         = 0;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 4'd6;
        waitrequest = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_reset_read", o_read, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_read", o_read, 0);
        chk("midreset_write", o_write, 0);
        chk("midreset_rsp_valid", o_rsp_valid, 0);
        chk("midreset_cmd_ready", o_cmd_ready, 0);
        chk("midreset_address", o_address, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_cmd_ready", o_cmd_ready, 1);
        chk("after_reset_read", o_read, 0);
        chk("after_reset_rsp_valid", o_rsp_valid, 0);

        run_txn(0, 1'b0, 4'd4, 32'h0, 32'h600DCAFE, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
